// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I ALU decode feeding a two-entry (head + skid) valid/ready issue buffer
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                         SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } entry_t;
  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'd0:    f3_op = ADD;
      3'd1:    f3_op = SLL;
      3'd2:    f3_op = SLT;
      3'd3:    f3_op = SLTU;
      3'd4:    f3_op = XOR;
      3'd5:    f3_op = SRL;
      3'd6:    f3_op = OR;
      default: f3_op = AND;
    endcase
  endfunction
  entry_t dec, head_q, head_d, skid_q, skid_d;
  logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic   legal, in_fire, shift_imm;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc       = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign shift_imm = f3 == 3'd1 || f3 == 3'd5;
  always_comb begin
    dec    = '0;
    dec.rd = in_instr[11:7];
    legal  = 1'b0;
    case (opc)
      7'b0110011: begin
        legal  = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        dec.a  = in_rs1_data;
        dec.b  = in_rs2_data;
        dec.op = f7 == 7'h20 ? (f3 == 3'd0 ? SUB : SRA) : f3_op(f3);
      end
      7'b0010011: begin
        legal  = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        dec.a  = in_rs1_data;
        dec.b  = shift_imm ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
        dec.op = (f3 == 3'd5 && f7 == 7'h20) ? SRA : f3_op(f3);
      end
      7'b0110111: begin
        legal = 1'b1;
        dec.b = {in_instr[31:12], 12'b0};
      end
      7'b0010111: begin
        legal = 1'b1;
        dec.a = in_pc;
        dec.b = {in_instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a  = '0;
      dec.b  = '0;
      dec.op = ADD;
    end
    dec.illegal = !legal;
    dec.wb_en   = legal && dec.rd != 5'd0;
  end
  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  // Skid only fills while the head is stalled; it always drains into the head first.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || out_ready) begin
      head_valid_d = skid_valid_q || in_fire;
      head_d       = skid_valid_q ? skid_q : in_fire ? dec : head_q;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign out_valid   = head_valid_q;
  assign out_a       = head_q.a;
  assign out_b       = head_q.b;
  assign out_alu_op  = head_q.op;
  assign out_rd      = head_q.rd;
  assign out_wb_en   = head_q.wb_en;
  assign out_illegal = head_q.illegal;
endmodule
